// File: rtl/riscv_definitions_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP and the
// instruction-memory boot-loader state encoding.
package riscv_definitions;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_WAIT,
    IMEM_LOAD,
    IMEM_RUN
  } imem_ld_state_t;

endpackage

// File: rtl/imem_byte_loader.sv
// Byte-stream boot loader: assembles little-endian words from a byte stream
// and issues one array write per completed word.
module imem_byte_loader
  import riscv_definitions::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ld_start,
  input  logic [15:0]           i_ld_len,
  input  logic [7:0]            i_ld_byte,
  input  logic                  i_ld_valid,
  output imem_ld_state_t        o_state,
  output logic                  o_ld_done,
  output logic                  o_wr_en,
  output logic [AW-1:0]         o_wr_idx,
  output logic [DATA_WIDTH-1:0] o_wr_word
);

  localparam int LW = AW + 1;

  imem_ld_state_t state_q, state_d;
  logic [1:0]     lane_q, lane_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [23:0]    asm_q, asm_d;
  logic           done_q, done_d;
  logic           wr_en;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IMEM_LOAD: begin
        if (i_ld_valid) begin
          if (lane_q == 2'd3) begin
            wr_en  = 1'b1;
            lane_d = 2'd0;
            ptr_d  = ptr_q + 1'b1;
            asm_d  = '0;
            if (LW'(ptr_q) == len_q - LW'(1)) begin
              state_d = IMEM_RUN;
              done_d  = 1'b1;
            end
          end else begin
            asm_d[{lane_q, 3'b000} +: 8] = i_ld_byte;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: begin
        // WAIT and RUN both accept a new load; a zero-length load just releases the core.
        if (i_ld_start) begin
          if (i_ld_len == 16'd0) begin
            state_d = IMEM_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = IMEM_LOAD;
            ptr_d   = '0;
            lane_d  = 2'd0;
            asm_d   = '0;
            if (int'(i_ld_len) > DEPTH_WORDS) len_d = LW'(DEPTH_WORDS);
            else                              len_d = LW'(i_ld_len);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IMEM_WAIT;
      lane_q  <= 2'd0;
      ptr_q   <= '0;
      len_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
    end
  end

  // A write in the reset cycle would commit a word the reset is meant to discard.
  assign o_wr_en   = wr_en & rst_n;
  assign o_wr_idx  = ptr_q;
  assign o_wr_word = {i_ld_byte, asm_q};
  assign o_state   = state_q;
  assign o_ld_done = done_q;

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory for the RV32I fetch stage: asynchronous-read word array
// filled by the byte loader, with the core held until loading completes.
module instruction_memory
  import riscv_definitions::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_inst_rd_enable,
  input  logic [31:0]           i_inst_addr,
  output logic [DATA_WIDTH-1:0] o_inst_data,
  output logic                  o_inst_fault,
  input  logic                  i_ld_start,
  input  logic [15:0]           i_ld_len,
  input  logic [7:0]            i_ld_byte,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  output logic                  o_ld_done,
  output logic                  o_core_hold
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  imem_ld_state_t        ld_state;
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  aligned;
  logic                  in_range;

  imem_byte_loader #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ld_start (i_ld_start),
    .i_ld_len   (i_ld_len),
    .i_ld_byte  (i_ld_byte),
    .i_ld_valid (i_ld_valid),
    .o_state    (ld_state),
    .o_ld_done  (o_ld_done),
    .o_wr_en    (wr_en),
    .o_wr_idx   (wr_idx),
    .o_wr_word  (wr_word)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_word;
  end

  assign aligned  = (i_inst_addr[1:0] == 2'b00);
  assign in_range = (i_inst_addr[31:AW+2] == '0);

  // Reads are only served in RUN, so they never race a loader write.
  always_comb begin
    o_inst_data = NOP_INST;
    if (i_inst_rd_enable && ld_state == IMEM_RUN && aligned && in_range)
      o_inst_data = mem[i_inst_addr[AW+1:2]];
  end

  assign o_inst_fault = i_inst_rd_enable & (~aligned | ~in_range);
  assign o_ld_ready   = (ld_state == IMEM_LOAD);
  assign o_core_hold  = (ld_state != IMEM_RUN);

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reset, loads with gaps, faults,
// reload and reset during a load.
module tb_instruction_memory;

  localparam int DEPTH_WORDS = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_inst_rd_enable;
  logic [31:0] i_inst_addr;
  logic [31:0] o_inst_data;
  logic        o_inst_fault;
  logic        i_ld_start;
  logic [15:0] i_ld_len;
  logic [7:0]  i_ld_byte;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic        o_ld_done;
  logic        o_core_hold;

  int n_vec  = 0;
  int n_miss = 0;

  instruction_memory #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_inst_rd_enable (i_inst_rd_enable),
    .i_inst_addr      (i_inst_addr),
    .o_inst_data      (o_inst_data),
    .o_inst_fault     (o_inst_fault),
    .i_ld_start       (i_ld_start),
    .i_ld_len         (i_ld_len),
    .i_ld_byte        (i_ld_byte),
    .i_ld_valid       (i_ld_valid),
    .o_ld_ready       (o_ld_ready),
    .o_ld_done        (o_ld_done),
    .o_core_hold      (o_core_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [15:0] len);
    i_ld_start = 1'b1;
    i_ld_len   = len;
    tick();
    i_ld_start = 1'b0;
    i_ld_len   = 16'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_ld_byte  = b;
    i_ld_valid = 1'b1;
    tick();
    i_ld_valid = 1'b0;
    i_ld_byte  = 8'h00;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_fault);
    i_inst_rd_enable = 1'b1;
    i_inst_addr      = addr;
    #1;
    check({tag, "_data"}, o_inst_data, exp_data);
    check({tag, "_fault"}, 32'(o_inst_fault), 32'(exp_fault));
  endtask

  initial begin
    rst_n            = 1'b0;
    i_inst_rd_enable = 1'b1;
    i_inst_addr      = 32'h0;
    i_ld_start       = 1'b0;
    i_ld_len         = 16'd0;
    i_ld_byte        = 8'h00;
    i_ld_valid       = 1'b0;

    repeat (3) tick();
    check("rst_hold",  32'(o_core_hold), 32'd1);
    check("rst_ready", 32'(o_ld_ready),  32'd0);
    check("rst_done",  32'(o_ld_done),   32'd0);
    read_chk("rst_read", 32'h0, NOP, 1'b0);
    rst_n = 1'b1;
    tick();
    check("wait_hold", 32'(o_core_hold), 32'd1);

    // Two-word load, back to back
    start_load(16'd2);
    check("ld1_ready", 32'(o_ld_ready),  32'd1);
    check("ld1_hold",  32'(o_core_hold), 32'd1);
    read_chk("ld1_read_in_load", 32'h4, NOP, 1'b0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0);
    check("ld1_hold_last", 32'(o_core_hold), 32'd1);
    send_byte(8'h00);
    check("ld1_done",  32'(o_ld_done),   32'd1);
    check("ld1_hold0", 32'(o_core_hold), 32'd0);
    check("ld1_ready0", 32'(o_ld_ready), 32'd0);
    read_chk("ld1_w1", 32'h4, 32'h00A0_0113, 1'b0);
    read_chk("ld1_w0", 32'h0, 32'h0050_0093, 1'b0);
    tick();
    check("ld1_done_gone", 32'(o_ld_done), 32'd0);

    // Reload from RUN with a 5-cycle gap and an ignored start mid-load
    start_load(16'd2);
    check("ld2_hold", 32'(o_core_hold), 32'd1);
    send_byte(8'h11); send_byte(8'h22);
    i_ld_start = 1'b1;
    i_ld_len   = 16'd0;
    tick();
    i_ld_start = 1'b0;
    repeat (4) tick();
    check("ld2_gap_ready", 32'(o_ld_ready), 32'd1);
    check("ld2_gap_done",  32'(o_ld_done),  32'd0);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77); send_byte(8'h88);
    check("ld2_done",  32'(o_ld_done),   32'd1);
    check("ld2_hold0", 32'(o_core_hold), 32'd0);
    read_chk("ld2_w0", 32'h0, 32'h4433_2211, 1'b0);
    read_chk("ld2_w1", 32'h4, 32'h8877_6655, 1'b0);
    tick();

    // Faults
    read_chk("flt_mis", 32'h6, NOP, 1'b1);
    read_chk("flt_oor", 32'(4 * DEPTH_WORDS), NOP, 1'b1);
    read_chk("flt_ok",  32'h0, 32'h4433_2211, 1'b0);
    i_inst_rd_enable = 1'b0;
    #1;
    check("rd_off_data",  o_inst_data, NOP);
    check("rd_off_fault", 32'(o_inst_fault), 32'd0);

    // Single-word reload from RUN
    start_load(16'd1);
    check("ld3_hold", 32'(o_core_hold), 32'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    check("ld3_done", 32'(o_ld_done), 32'd1);
    read_chk("ld3_w0", 32'h0, 32'h0000_0513, 1'b0);
    read_chk("ld3_w1", 32'h4, 32'h8877_6655, 1'b0);
    tick();

    // Reset after six bytes of a four-word load
    start_load(16'd4);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    rst_n = 1'b0;
    tick();
    check("mrst_hold",  32'(o_core_hold), 32'd1);
    check("mrst_ready", 32'(o_ld_ready),  32'd0);
    read_chk("mrst_read", 32'h0, NOP, 1'b0);
    rst_n = 1'b1;
    tick();
    start_load(16'd0);
    check("zl_done", 32'(o_ld_done),   32'd1);
    check("zl_hold", 32'(o_core_hold), 32'd0);
    read_chk("mrst_w0", 32'h0, 32'hDDCC_BBAA, 1'b0);
    read_chk("mrst_w1", 32'h4, 32'h8877_6655, 1'b0);
    tick();
    check("zl_done_gone", 32'(o_ld_done), 32'd0);
    check("zl_hold_run",  32'(o_core_hold), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
